// File: rtl/sparc_exu_ecc_corr_ctl.sv
// ECC correction controller: picks one of two requesters (round-robin),
// decodes the captured syndrome through an external one-hot decoder,
// classifies and corrects the word, and returns it through a valid/ready
// response. Also keeps saturating counts of correctable and uncorrectable events.
module sparc_exu_ecc_corr_ctl #(
  parameter int CNT_W = 8
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             req0_vld,
  input  logic             req1_vld,
  input  logic [63:0]      req0_data,
  input  logic [63:0]      req1_data,
  input  logic [6:0]       req0_syn,
  input  logic [6:0]       req1_syn,
  input  logic             req0_par,
  input  logic             req1_par,
  output logic             req0_rdy,
  output logic             req1_rdy,
  output logic [6:0]       dec_q,
  input  logic [63:0]      dec_e,
  output logic             cor_vld,
  input  logic             cor_rdy,
  output logic [63:0]      cor_data,
  output logic             cor_id,
  output logic             cor_ce,
  output logic             cor_ue,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ce_cnt,
  output logic [CNT_W-1:0] ue_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             ptr_q;
  logic [63:0]      data_q;
  logic [6:0]       syn_q;
  logic             par_q;
  logic             id_q;
  logic [63:0]      cor_data_q;
  logic             cor_id_q, cor_ce_q, cor_ue_q;
  logic [CNT_W-1:0] ce_cnt_q, ue_cnt_q;

  logic             gnt0, gnt1, accept, in_idle, hs;
  logic             syn_nz, syn_one;
  logic [63:0]      fix_data;
  logic             fix_ce, fix_ue;

  // Round-robin: on contention the requester not granted last wins.
  assign in_idle  = (state_q == IDLE);
  assign gnt0     = req0_vld & (~req1_vld | ptr_q);
  assign gnt1     = req1_vld & (~req0_vld | ~ptr_q);
  assign req0_rdy = in_idle & gnt0 & ~reset;
  assign req1_rdy = in_idle & gnt1 & ~reset;
  assign accept   = (req0_vld & req0_rdy) | (req1_vld & req1_rdy);

  assign dec_q    = (state_q == DECODE) ? syn_q : 7'h00;
  assign cor_vld  = (state_q == RESP);
  assign hs       = cor_vld & cor_rdy;
  assign cor_data = cor_data_q;
  assign cor_id   = cor_id_q;
  assign cor_ce   = cor_ce_q;
  assign cor_ue   = cor_ue_q;
  assign ce_cnt   = ce_cnt_q;
  assign ue_cnt   = ue_cnt_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = DECODE;
      DECODE:  state_d = RESP;
      RESP:    if (cor_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Classify the captured word; a single-bit syndrome with parity error
  // means a check bit flipped, so the data itself is already good.
  always_comb begin
    syn_nz   = |syn_q;
    syn_one  = syn_nz & ~|(syn_q & (syn_q - 7'd1));
    fix_data = data_q;
    fix_ce   = 1'b0;
    fix_ue   = 1'b0;
    if (!syn_nz && !par_q) begin
      fix_ce = 1'b0;
    end else if (syn_nz && par_q && (|dec_e)) begin
      fix_data = data_q ^ dec_e;
      fix_ce   = 1'b1;
    end else if (par_q && (!syn_nz || syn_one)) begin
      fix_ce = 1'b1;
    end else begin
      fix_ue = 1'b1;
    end
  end

  // State register, arbitration pointer and request capture.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      data_q  <= '0;
      syn_q   <= '0;
      par_q   <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_idle && accept) begin
        ptr_q  <= req1_rdy;
        id_q   <= req1_rdy;
        data_q <= req1_rdy ? req1_data : req0_data;
        syn_q  <= req1_rdy ? req1_syn  : req0_syn;
        par_q  <= req1_rdy ? req1_par  : req0_par;
      end
    end
  end

  // Response registers, loaded once in DECODE and held through RESP.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      cor_data_q <= '0;
      cor_id_q   <= 1'b0;
      cor_ce_q   <= 1'b0;
      cor_ue_q   <= 1'b0;
    end else if (state_q == DECODE) begin
      cor_data_q <= fix_data;
      cor_id_q   <= id_q;
      cor_ce_q   <= fix_ce;
      cor_ue_q   <= fix_ue;
    end
  end

  // Saturating event counters; clear has priority over a handshake.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
    end else if (cnt_clr) begin
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
    end else if (hs) begin
      if (cor_ce_q && (ce_cnt_q != CNT_MAX)) ce_cnt_q <= ce_cnt_q + CNT_ONE;
      if (cor_ue_q && (ue_cnt_q != CNT_MAX)) ue_cnt_q <= ue_cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_sparc_exu_ecc_corr_ctl.sv
// Bench for sparc_exu_ecc_corr_ctl: responses are checked against a
// scoreboard filled at accept time from a reference classifier.
module tb_sparc_exu_ecc_corr_ctl;

  logic        rclk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_vld = 1'b0, req1_vld = 1'b0;
  logic [63:0] req0_data = '0, req1_data = '0;
  logic [6:0]  req0_syn = '0, req1_syn = '0;
  logic        req0_par = 1'b0, req1_par = 1'b0;
  logic        req0_rdy, req1_rdy;
  logic [6:0]  dec_q;
  logic [63:0] dec_e;
  logic        cor_vld, cor_rdy = 1'b1;
  logic [63:0] cor_data;
  logic        cor_id, cor_ce, cor_ue;
  logic        cnt_clr = 1'b0;
  logic [7:0]  ce_cnt, ue_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        id;
    logic        ce;
    logic        ue;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_ce = 8'd0;
  logic [7:0] exp_ue = 8'd0;

  always #5 rclk = ~rclk;

  sparc_exu_ecc_corr_ctl #(.CNT_W(8)) dut (
    .rclk(rclk), .reset(reset),
    .req0_vld(req0_vld), .req1_vld(req1_vld),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_syn(req0_syn), .req1_syn(req1_syn),
    .req0_par(req0_par), .req1_par(req1_par),
    .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
    .dec_q(dec_q), .dec_e(dec_e),
    .cor_vld(cor_vld), .cor_rdy(cor_rdy), .cor_data(cor_data),
    .cor_id(cor_id), .cor_ce(cor_ce), .cor_ue(cor_ue),
    .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
  );

  // External decoder stand-in: check-bit syndromes and 7'h7F map to no bit.
  function automatic logic [63:0] dec_fn(input logic [6:0] s);
    if (s == 7'h00 || $countones(s) == 1 || s == 7'h7F) return 64'd0;
    if (s == 7'h0A) return 64'h20;
    return 64'd1 << s[5:0];
  endfunction

  assign dec_e = dec_fn(dec_q);

  function automatic exp_t model(input logic [63:0] d, input logic [6:0] s,
                                 input logic p, input logic id);
    exp_t r;
    logic [63:0] e;
    e = dec_fn(s);
    r.data = d; r.id = id; r.ce = 1'b0; r.ue = 1'b0;
    if (s == 7'h00 && !p) r.ce = 1'b0;
    else if (s != 7'h00 && p && e != 64'd0) begin r.data = d ^ e; r.ce = 1'b1; end
    else if (p && $countones(s) <= 1) r.ce = 1'b1;
    else r.ue = 1'b1;
    return r;
  endfunction

  // Record expectations at accept.
  always @(negedge rclk) begin
    if (!reset) begin
      if (req0_vld && req0_rdy) sb.push_back(model(req0_data, req0_syn, req0_par, 1'b0));
      if (req1_vld && req1_rdy) sb.push_back(model(req1_data, req1_syn, req1_par, 1'b1));
    end
  end

  // Compare responses and track the expected counters.
  always @(negedge rclk) begin
    exp_t e;
    logic hce, hue;
    if (!reset) begin
      hce = 1'b0; hue = 1'b0;
      if (cor_vld && cor_rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got data=%h id=%0d with no pending request", cor_data, cor_id);
        end else begin
          e = sb.pop_front();
          hce = e.ce; hue = e.ue;
          if ({cor_data, cor_id, cor_ce, cor_ue} !== {e.data, e.id, e.ce, e.ue}) begin
            errors++;
            $display("FAIL resp: got data=%h id=%0d ce=%0d ue=%0d, want data=%h id=%0d ce=%0d ue=%0d",
                     cor_data, cor_id, cor_ce, cor_ue, e.data, e.id, e.ce, e.ue);
          end
        end
      end
      if (cnt_clr) begin
        exp_ce = 8'd0; exp_ue = 8'd0;
      end else begin
        if (hce && exp_ce != 8'hFF) exp_ce = exp_ce + 8'd1;
        if (hue && exp_ue != 8'hFF) exp_ue = exp_ue + 8'd1;
      end
      checks++;
      if (req0_rdy && req1_rdy) begin
        errors++;
        $display("FAIL rdy_onehot: req0_rdy=%0d req1_rdy=%0d, want at most one", req0_rdy, req1_rdy);
      end
    end
  end

  task automatic tick;
    @(posedge rclk); #1;
  endtask

  task automatic do_reset;
    req0_vld = 1'b0; req1_vld = 1'b0; cnt_clr = 1'b0; cor_rdy = 1'b1;
    reset = 1'b1;
    sb.delete(); exp_ce = 8'd0; exp_ue = 8'd0;
    tick; tick;
    reset = 1'b0;
  endtask

  // Present one request and return once it is accepted (now in DECODE).
  task automatic send(input logic id, input logic [63:0] d, input logic [6:0] s,
                      input logic p, output logic ok);
    tick;
    if (id) begin req1_vld = 1'b1; req1_data = d; req1_syn = s; req1_par = p; end
    else    begin req0_vld = 1'b1; req0_data = d; req0_syn = s; req0_par = p; end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge rclk);
      if (id ? req1_rdy : req0_rdy) ok = 1'b1;
    end
    tick;
    req0_vld = 1'b0; req1_vld = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    req0_vld = 1'b1; req1_vld = 1'b1;
    #3;
    checks++;
    if ({req0_rdy, req1_rdy, cor_vld, cor_ce, cor_ue, cor_id} !== 6'b0 ||
        cor_data !== 64'd0 || dec_q !== 7'd0 || ce_cnt !== 8'd0 || ue_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_vals: rdy=%b%b vld=%0d ce=%0d ue=%0d id=%0d data=%h dec_q=%h cnt=%0d/%0d, want all 0",
               req0_rdy, req1_rdy, cor_vld, cor_ce, cor_ue, cor_id, cor_data, dec_q, ce_cnt, ue_cnt);
    end
    do_reset;
  endtask

  task automatic test_clean;
    logic ok;
    send(1'b0, 64'hDEADBEEF_01234567, 7'h00, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_accept: got no accept, want accept"); end
    @(negedge rclk);
    checks++;
    if (cor_vld !== 1'b0) begin errors++; $display("FAIL clean_lat1: cor_vld=%0d, want 0", cor_vld); end
    @(negedge rclk);
    checks++;
    if (cor_vld !== 1'b1 || cor_data !== 64'hDEADBEEF_01234567 || cor_ce !== 1'b0 ||
        cor_ue !== 1'b0 || cor_id !== 1'b0) begin
      errors++;
      $display("FAIL clean_resp: vld=%0d data=%h ce=%0d ue=%0d id=%0d, want 1 deadbeef01234567 0 0 0",
               cor_vld, cor_data, cor_ce, cor_ue, cor_id);
    end
    tick; tick;
  endtask

  task automatic test_single;
    logic ok;
    send(1'b1, 64'h01234567_89ABCDEF ^ 64'h20, 7'h0A, 1'b1, ok);
    @(negedge rclk);
    checks++;
    if (!ok || dec_q !== 7'h0A) begin
      errors++; $display("FAIL single_decq: accepted=%0d dec_q=%h, want 1 0a", ok, dec_q);
    end
    @(negedge rclk);
    checks++;
    if (cor_data !== 64'h01234567_89ABCDEF || cor_ce !== 1'b1 || cor_id !== 1'b1) begin
      errors++;
      $display("FAIL single_fix: data=%h ce=%0d id=%0d, want 0123456789abcdef 1 1", cor_data, cor_ce, cor_id);
    end
    tick; tick;
    checks++;
    if (ce_cnt !== 8'd1 || ce_cnt !== exp_ce) begin
      errors++; $display("FAIL single_cnt: ce_cnt=%0d, want 1", ce_cnt);
    end
  endtask

  task automatic test_double_checkbit;
    logic ok;
    send(1'b0, 64'hCAFEF00D_12345678, 7'h13, 1'b0, ok);
    @(negedge rclk); @(negedge rclk);
    checks++;
    if (!ok || cor_ue !== 1'b1 || cor_ce !== 1'b0 || cor_data !== 64'hCAFEF00D_12345678) begin
      errors++;
      $display("FAIL double: ue=%0d ce=%0d data=%h, want 1 0 cafef00d12345678", cor_ue, cor_ce, cor_data);
    end
    send(1'b0, 64'h55AA55AA_00FF00FF, 7'h04, 1'b1, ok);
    @(negedge rclk); @(negedge rclk);
    checks++;
    if (!ok || cor_ce !== 1'b1 || cor_ue !== 1'b0 || cor_data !== 64'h55AA55AA_00FF00FF) begin
      errors++;
      $display("FAIL checkbit: ce=%0d ue=%0d data=%h, want 1 0 55aa55aa00ff00ff", cor_ce, cor_ue, cor_data);
    end
    send(1'b1, 64'h1111_2222_3333_4444, 7'h7F, 1'b1, ok);
    @(negedge rclk); @(negedge rclk);
    checks++;
    if (!ok || cor_ue !== 1'b1 || cor_ce !== 1'b0) begin
      errors++; $display("FAIL nodec_ue: ue=%0d ce=%0d, want 1 0", cor_ue, cor_ce);
    end
    tick; tick;
    checks++;
    if (ce_cnt !== 8'd2 || ue_cnt !== 8'd2 || ce_cnt !== exp_ce || ue_cnt !== exp_ue) begin
      errors++; $display("FAIL cnt_mix: ce_cnt=%0d ue_cnt=%0d, want 2 2", ce_cnt, ue_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic        ids [4];
    int          when [4];
    int          n;
    logic [63:0] snap_d;
    logic [2:0]  snap_f;
    do_reset;
    n = 0;
    tick;
    req0_vld = 1'b1; req1_vld = 1'b1;
    req0_syn = 7'h00; req0_par = 1'b0; req1_syn = 7'h13; req1_par = 1'b0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge rclk);
      if (req0_rdy || req1_rdy) begin ids[n] = req1_rdy; when[n] = c; n++; end
      if (n < 4) begin
        tick;
        req0_data = {32'hA0A0A0A0, 32'(c)};
        req1_data = {32'hB1B1B1B1, 32'(c)};
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL b2b_count: got %0d accepts, want 4", n); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ids[i] !== 1'(i % 2)) begin
          errors++; $display("FAIL b2b_order[%0d]: got id %0d, want %0d", i, ids[i], i % 2);
        end
      end
      checks++;
      if (when[1] - when[0] != 3 || when[3] - when[2] != 3) begin
        errors++; $display("FAIL b2b_spacing: gaps %0d %0d, want 3 3", when[1] - when[0], when[3] - when[2]);
      end
    end
    tick;
    cor_rdy = 1'b0;
    @(negedge rclk); @(negedge rclk);
    snap_d = cor_data; snap_f = {cor_id, cor_ce, cor_ue};
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      checks++;
      if (cor_vld !== 1'b1 || cor_data !== snap_d || {cor_id, cor_ce, cor_ue} !== snap_f ||
          req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: vld=%0d data=%h flags=%b rdy=%b%b, want 1 %h %b 00",
                 i, cor_vld, cor_data, {cor_id, cor_ce, cor_ue}, req0_rdy, req1_rdy, snap_d, snap_f);
      end
    end
    tick;
    cor_rdy = 1'b1; req0_vld = 1'b0; req1_vld = 1'b0;
    tick; tick;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d responses missing, want 0", sb.size()); end
  endtask

  task automatic test_counters;
    int  n;
    logic ok;
    do_reset;
    n = 0;
    tick;
    req0_vld = 1'b1; req0_syn = 7'h04; req0_par = 1'b1; req0_data = 64'h0F0F;
    for (int c = 0; c < 1200 && n < 300; c++) begin
      @(negedge rclk);
      if (req0_rdy) n++;
      tick;
      if (n >= 300) req0_vld = 1'b0;
    end
    tick; tick; tick; tick;
    checks++;
    if (n != 300 || ce_cnt !== 8'hFF || ce_cnt !== exp_ce || ue_cnt !== 8'd0) begin
      errors++; $display("FAIL ce_sat: accepts=%0d ce_cnt=%0d ue_cnt=%0d, want 300 255 0", n, ce_cnt, ue_cnt);
    end
    send(1'b0, 64'h1234, 7'h04, 1'b1, ok);
    tick;
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    @(negedge rclk);
    checks++;
    if (!ok || ce_cnt !== 8'd0 || ce_cnt !== exp_ce || cor_vld !== 1'b0) begin
      errors++; $display("FAIL clr_wins: ce_cnt=%0d vld=%0d, want 0 0", ce_cnt, cor_vld);
    end
  endtask

  task automatic test_reset_mid;
    logic ok;
    int   rises;
    do_reset;
    send(1'b0, 64'hFFFF0000FFFF0000, 7'h0A, 1'b1, ok);
    reset = 1'b1;
    sb.delete();
    tick; tick;
    reset = 1'b0;
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk);
      if (cor_vld !== 1'b0) rises++;
    end
    checks++;
    if (!ok || rises != 0 || ce_cnt !== 8'd0 || ue_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: accepted=%0d vld_cycles=%0d cnt=%0d/%0d, want 1 0 0/0", ok, rises, ce_cnt, ue_cnt);
    end
    tick;
    req0_vld = 1'b1; req1_vld = 1'b1;
    req0_syn = 7'h00; req0_par = 1'b0; req1_syn = 7'h00; req1_par = 1'b0;
    @(negedge rclk);
    checks++;
    if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
      errors++; $display("FAIL post_reset_grant: rdy0=%0d rdy1=%0d, want 1 0", req0_rdy, req1_rdy);
    end
    tick;
    req0_vld = 1'b0; req1_vld = 1'b0;
    tick; tick; tick;
  endtask

  initial begin
    test_reset;
    test_clean;
    test_single;
    test_double_checkbit;
    test_back_to_back;
    test_counters;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL final_drain: %0d responses missing, want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
